calc1_port_driver: RTL
======================

Name: calc1_port_driver

Overview:
- Upstream request stage for one calc1 port. Accepts a complete transaction (cmd, operand1, operand2) over a valid/ready handshake.
- Serialises the transaction onto the calc1 two-cycle request protocol, waits for the port response, and returns the response code and data over a valid/ready result handshake.
- Four instances, one per port, feed the calc1 request inputs.

Parameters:
- DATA_W, 32, operand/result width
- CMD_W, 4, command width
- TIMEOUT_CYCLES, 64, WAIT_RESP cycles allowed before a driver-side timeout (minimum 2)
- CNT_W, 16, transaction counter width

Ports:
- c_clk  in  1  clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  transaction offered
- in_ready  out  1  driver can accept a transaction
- in_cmd  in  CMD_W  command code
- in_op1  in  DATA_W  first operand
- in_op2  in  DATA_W  second operand
- req_cmd_out  out  CMD_W  to calc1 reqN_cmd_in
- req_data_out  out  DATA_W  to calc1 reqN_data_in
- duv_resp  in  2  from calc1 out_respN
- duv_data  in  DATA_W  from calc1 out_dataN
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_resp  out  2  captured response code (0 none, 1 success, 2 error, 3 timeout)
- rsp_data  out  DATA_W  captured result data
- rsp_timeout  out  1  result produced by timeout
- err_spurious  out  1  sticky: nonzero duv_resp seen outside WAIT_RESP
- txn_count  out  CNT_W  completed transactions, wraps

Behaviour:
- Reset (reset_n=0, asynchronous):
  - State goes to IDLE; all outputs and registers go to 0, except in_ready, which is 1 immediately.
  - An in-flight transaction is discarded and no result is produced.
  - After reset_n rises, the first accept is possible on the first rising edge.
- States: IDLE, SEND_OP1, SEND_OP2, WAIT_RESP, DONE.
- IDLE:
  - in_ready=1; req_cmd_out=0, req_data_out=0.
  - On in_valid, capture cmd/op1/op2.
  - If in_cmd=0, go to DONE with rsp_resp=0, rsp_data=0. Nothing is sent to calc1.
  - Otherwise go to SEND_OP1.
- SEND_OP1: drive req_cmd_out=cmd, req_data_out=op1 for exactly one cycle, then SEND_OP2.
- SEND_OP2: drive req_cmd_out=0, req_data_out=op2 for exactly one cycle. Clear the timeout counter, then WAIT_RESP.
- WAIT_RESP:
  - Drive cmd=0, data=0.
  - If duv_resp!=0 on an edge: capture duv_resp/duv_data into rsp_resp/rsp_data, rsp_timeout=0, go to DONE.
  - Else increment the counter. When the counter reaches TIMEOUT_CYCLES-1 without a response: rsp_resp=3, rsp_data=0, rsp_timeout=1, go to DONE.
  - If a response and the timeout coincide on the same edge, the response wins.
- DONE:
  - rsp_valid=1 with rsp_* held stable until rsp_valid&&rsp_ready on an edge.
  - On that edge: txn_count+1 (wraps at 2^CNT_W), return to IDLE.
  - in_ready=0 in DONE; no accept on the same edge as result handoff.
- Invalid commands (3, 4, 7-15) are forwarded unchanged. calc1 answers with resp 2, which is captured normally.
- Latency: accept edge T; op1 on the port during T..T+1; op2 during T+1..T+2; response sampled on edge R ≥ T+3; rsp_valid=1 from R. Minimum accept-to-accept interval is 5 cycles.
- err_spurious: set when duv_resp!=0 on an edge in IDLE, SEND_OP1, SEND_OP2 or DONE. Cleared only by reset.
- Data passes through unmodified; there is no arithmetic in the driver.

Decomposition:
- Shared package calc1_pkg:
  - command codes CMD_NOP=0, CMD_ADD=1, CMD_SUB=2, CMD_SHL=5, CMD_SHR=6
  - response codes RESP_NONE=0, RESP_OK=1, RESP_ERR=2, RESP_TIMEOUT=3
  - DATA_W, CMD_W
  - state enum for the driver FSM
- No sub-module required. The timeout counter and FSM stay inline.

Test Plan:
- Add 0x1 + 0x1FF_FFFF (calc1 attached) -> port sees cmd 1/data 0x1 then cmd 0/data 0x1FF_FFFF; rsp_resp=1, rsp_data=0x200_0000; txn_count=1.
- Add 0xFFFF_FFFF + 0x1 -> rsp_resp=2, rsp_timeout=0. Sub 0x1 - 0xF -> rsp_resp=2.
- cmd 3 with op1=1, op2=0 -> forwarded unchanged; rsp_resp=2. cmd 0 -> rsp_valid within 1 cycle, rsp_resp=0, req_cmd_out never nonzero.
- Stub that never responds, TIMEOUT_CYCLES=16 -> rsp_valid 16 cycles after entering WAIT_RESP; rsp_resp=3, rsp_timeout=1, rsp_data=0.
- Add 0x64 + 0x64 with rsp_ready held low 5 cycles -> rsp_valid and rsp_data=0xC8 stable throughout; in_ready=0 until the handoff edge; then IDLE.
- reset_n pulsed low during WAIT_RESP -> outputs 0 and in_ready=1 immediately, no rsp_valid. Late duv_resp=1 arriving afterwards -> err_spurious=1.

Source files
------------

// File: rtl/calc1_pkg.sv
// Shared definitions for the calc1 port driver: widths, command/response
// codes and the driver FSM state encoding.
package calc1_pkg;

    localparam int DATA_W = 32;
    localparam int CMD_W  = 4;

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    localparam logic [1:0] RESP_NONE    = 2'd0;
    localparam logic [1:0] RESP_OK      = 2'd1;
    localparam logic [1:0] RESP_ERR     = 2'd2;
    localparam logic [1:0] RESP_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND_OP1  = 3'd1,
        ST_SEND_OP2  = 3'd2,
        ST_WAIT_RESP = 3'd3,
        ST_DONE      = 3'd4
    } drv_state_e;

endpackage

// File: rtl/calc1_port_driver.sv
// Request stage for one calc1 port: serialises a (cmd, op1, op2) transaction
// onto the two-cycle request protocol and returns the response via valid/ready.
module calc1_port_driver #(
    parameter int DATA_W         = calc1_pkg::DATA_W,
    parameter int CMD_W          = calc1_pkg::CMD_W,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic              c_clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CMD_W-1:0]  in_cmd,
    input  logic [DATA_W-1:0] in_op1,
    input  logic [DATA_W-1:0] in_op2,
    output logic [CMD_W-1:0]  req_cmd_out,
    output logic [DATA_W-1:0] req_data_out,
    input  logic [1:0]        duv_resp,
    input  logic [DATA_W-1:0] duv_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_resp,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_timeout,
    output logic              err_spurious,
    output logic [CNT_W-1:0]  txn_count
);
    import calc1_pkg::*;

    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    drv_state_e        state_q, state_d;
    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic [DATA_W-1:0] op1_q, op1_d;
    logic [DATA_W-1:0] op2_q, op2_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic [1:0]        rsp_resp_q, rsp_resp_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic              err_spurious_q, err_spurious_d;
    logic [CNT_W-1:0]  txn_count_q, txn_count_d;

    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            cmd_q          <= '0;
            op1_q          <= '0;
            op2_q          <= '0;
            cnt_q          <= '0;
            rsp_resp_q     <= '0;
            rsp_data_q     <= '0;
            rsp_timeout_q  <= 1'b0;
            err_spurious_q <= 1'b0;
            txn_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            cmd_q          <= cmd_d;
            op1_q          <= op1_d;
            op2_q          <= op2_d;
            cnt_q          <= cnt_d;
            rsp_resp_q     <= rsp_resp_d;
            rsp_data_q     <= rsp_data_d;
            rsp_timeout_q  <= rsp_timeout_d;
            err_spurious_q <= err_spurious_d;
            txn_count_q    <= txn_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        op1_d         = op1_q;
        op2_d         = op2_q;
        cnt_d         = cnt_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_data_d    = rsp_data_q;
        rsp_timeout_d = rsp_timeout_q;
        txn_count_d   = txn_count_q;
        in_ready      = 1'b0;
        rsp_valid     = 1'b0;
        req_cmd_out   = '0;
        req_data_out  = '0;

        // Any response outside the wait window points at a protocol problem upstream.
        err_spurious_d = err_spurious_q |
                         ((duv_resp != RESP_NONE) && (state_q != ST_WAIT_RESP));

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    cmd_d = in_cmd;
                    op1_d = in_op1;
                    op2_d = in_op2;
                    if (in_cmd == '0) begin
                        rsp_resp_d    = RESP_NONE;
                        rsp_data_d    = '0;
                        rsp_timeout_d = 1'b0;
                        state_d       = ST_DONE;
                    end else begin
                        state_d = ST_SEND_OP1;
                    end
                end
            end
            ST_SEND_OP1: begin
                req_cmd_out  = cmd_q;
                req_data_out = op1_q;
                state_d      = ST_SEND_OP2;
            end
            ST_SEND_OP2: begin
                req_data_out = op2_q;
                cnt_d        = '0;
                state_d      = ST_WAIT_RESP;
            end
            ST_WAIT_RESP: begin
                // A response on the final cycle still beats the timeout.
                if (duv_resp != RESP_NONE) begin
                    rsp_resp_d    = duv_resp;
                    rsp_data_d    = duv_data;
                    rsp_timeout_d = 1'b0;
                    state_d       = ST_DONE;
                end else if (cnt_q == TO_LAST) begin
                    rsp_resp_d    = RESP_TIMEOUT;
                    rsp_data_d    = '0;
                    rsp_timeout_d = 1'b1;
                    state_d       = ST_DONE;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            ST_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    txn_count_d = txn_count_q + CNT_W'(1);
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rsp_resp     = rsp_resp_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_timeout  = rsp_timeout_q;
    assign err_spurious = err_spurious_q;
    assign txn_count    = txn_count_q;

endmodule
